// File: rtl/opc_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : opc_mem_pkg
// Brief    : Shared types for the OPC CPU/DMA memory arbiter.
// Revision : 1.0
// ============================================================================
package opc_mem_pkg;

  localparam int c_wait_w = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CPU_ACC = 2'd1,
    DMA_ACC = 2'd2
  } state_t;

  typedef enum logic {
    GNT_CPU = 1'b0,
    GNT_DMA = 1'b1
  } gnt_t;

endpackage
`default_nettype wire

// File: rtl/opc_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : opc_rr_arb2
// Brief    : Two-way round-robin decision between CPU and DMA requesters.
// Revision : 1.0
// ============================================================================
module opc_rr_arb2
  import opc_mem_pkg::*;
(
  input  logic i_req_cpu,
  input  logic i_req_dma,
  input  gnt_t i_last_gnt,
  output logic o_gnt_valid,
  output gnt_t o_gnt
);

  always_comb begin
    o_gnt_valid = i_req_cpu | i_req_dma;
    o_gnt       = GNT_CPU;
    if (i_req_cpu && i_req_dma) begin
      o_gnt = (i_last_gnt == GNT_CPU) ? GNT_DMA : GNT_CPU;
    end else if (i_req_dma) begin
      o_gnt = GNT_DMA;
    end
  end

endmodule
`default_nettype wire

// File: rtl/opc_mem_arb.sv
`default_nettype none
// ============================================================================
// Module   : opc_mem_arb
// Brief    : Shares one synchronous SRAM between the CPU and a DMA master.
// Revision : 1.0
// ============================================================================
module opc_mem_arb
  import opc_mem_pkg::*;
#(
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_dout,
  input  logic        cpu_rnw,
  input  logic        cpu_vda,
  input  logic        cpu_vpa,
  output logic [15:0] cpu_din,
  output logic        cpu_clken,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [15:0] dma_addr,
  input  logic [15:0] dma_wdata,
  output logic        dma_ack,
  output logic [15:0] dma_rdata,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [15:0] mem_rdata
);

  localparam logic [c_wait_w-1:0] c_wait_last = c_wait_w'(WAIT_STATES);

  state_t              r_state, w_state_nxt;
  logic [c_wait_w-1:0] r_wait, w_wait_nxt;
  gnt_t                r_last, w_last_nxt;
  gnt_t                w_gnt;
  logic                w_gnt_valid;
  logic                w_cpu_req, w_cpu_wr;
  logic                w_final, w_cycle0, w_arb_en;
  logic                w_arb_cpu, w_arb_dma;

  assign w_cpu_req = cpu_vda | cpu_vpa;
  assign w_cpu_wr  = cpu_vda & ~cpu_rnw;
  assign w_final   = (r_state != IDLE) && (r_wait == c_wait_last);
  assign w_cycle0  = (r_state != IDLE) && (r_wait == '0);
  assign w_arb_en  = (r_state == IDLE) || w_final;

  // In its final cycle the served master still shows the request being retired.
  assign w_arb_cpu = w_cpu_req && (r_state != CPU_ACC);
  assign w_arb_dma = dma_req   && (r_state != DMA_ACC);

  opc_rr_arb2 u_rr (
    .i_req_cpu   (w_arb_cpu),
    .i_req_dma   (w_arb_dma),
    .i_last_gnt  (r_last),
    .o_gnt_valid (w_gnt_valid),
    .o_gnt       (w_gnt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_wait  <= '0;
      r_last  <= GNT_DMA;
    end else begin
      r_state <= w_state_nxt;
      r_wait  <= w_wait_nxt;
      r_last  <= w_last_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait;
    w_last_nxt  = r_last;
    if ((r_state != IDLE) && (r_wait != c_wait_last)) begin
      w_wait_nxt = r_wait + 1'b1;
    end
    if (w_arb_en) begin
      if (w_gnt_valid) begin
        w_state_nxt = (w_gnt == GNT_CPU) ? CPU_ACC : DMA_ACC;
        w_wait_nxt  = '0;
        w_last_nxt  = w_gnt;
      end else begin
        w_state_nxt = IDLE;
      end
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    dma_ack   = 1'b0;
    cpu_clken = 1'b1;
    if (!reset) begin
      cpu_clken = ~w_cpu_req;
      case (r_state)
        CPU_ACC: begin
          mem_addr  = cpu_addr;
          mem_wdata = cpu_dout;
          mem_we    = w_cycle0 & w_cpu_wr;
          mem_re    = w_cycle0 & ~w_cpu_wr;
          cpu_clken = w_final;
        end
        DMA_ACC: begin
          mem_addr  = dma_addr;
          mem_wdata = dma_wdata;
          mem_we    = w_cycle0 & dma_we;
          mem_re    = w_cycle0 & ~dma_we;
          dma_ack   = w_final;
        end
        default: ;
      endcase
    end
  end

  assign cpu_din   = mem_rdata;
  assign dma_rdata = mem_rdata;

endmodule
`default_nettype wire

// File: tb/tb_opc_mem_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_opc_mem_arb
// Brief    : Self-checking bench for opc_mem_arb against a transaction model.
// Revision : 1.0
// ============================================================================
module tb_opc_mem_arb;

  localparam int WS = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_addr, cpu_dout, cpu_din;
  logic        cpu_rnw, cpu_vda, cpu_vpa, cpu_clken;
  logic        dma_req, dma_we, dma_ack;
  logic [15:0] dma_addr, dma_wdata, dma_rdata;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we, mem_re;

  logic [15:0] c3_addr, c3_din, d3_rdata, m3_addr, m3_wdata, m3_rdata;
  logic        c3_vpa, c3_clken, d3_ack, m3_we, m3_re;

  always #5 clk = ~clk;

  opc_mem_arb #(.WAIT_STATES(WS)) dut (
    .clk(clk), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_rnw(cpu_rnw),
    .cpu_vda(cpu_vda), .cpu_vpa(cpu_vpa), .cpu_din(cpu_din), .cpu_clken(cpu_clken),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata)
  );

  opc_mem_arb #(.WAIT_STATES(3)) dut3 (
    .clk(clk), .reset(reset),
    .cpu_addr(c3_addr), .cpu_dout(16'h0000), .cpu_rnw(1'b1),
    .cpu_vda(1'b0), .cpu_vpa(c3_vpa), .cpu_din(c3_din), .cpu_clken(c3_clken),
    .dma_req(1'b0), .dma_we(1'b0), .dma_addr(16'h0000), .dma_wdata(16'h0000),
    .dma_ack(d3_ack), .dma_rdata(d3_rdata),
    .mem_addr(m3_addr), .mem_wdata(m3_wdata), .mem_we(m3_we), .mem_re(m3_re),
    .mem_rdata(m3_rdata)
  );

  function automatic logic [15:0] init_val(input logic [15:0] a);
    return a ^ 16'hC35A;
  endfunction

  // Synchronous SRAM: data appears the cycle after the read strobe.
  logic [15:0] mem    [0:65535];
  bit          mem_wr [0:65535];
  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr]    <= mem_wdata;
      mem_wr[mem_addr] <= 1'b1;
    end
    if (mem_re) mem_rdata <= mem_wr[mem_addr] ? mem[mem_addr] : init_val(mem_addr);
  end
  always @(posedge clk) if (m3_re) m3_rdata <= init_val(m3_addr);

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // kind: CPU 0 idle, 1 fetch, 2 data read, 3 data write; DMA 0 gap, 1 read, 2 write
  typedef struct {
    int          kind;
    logic [15:0] addr;
    logic [15:0] data;
  } op_t;

  op_t cpu_q[$];
  op_t dma_q[$];

  function automatic op_t mk(input int k, input logic [15:0] a, input logic [15:0] d);
    op_t o;
    o.kind = k;
    o.addr = a;
    o.data = d;
    return o;
  endfunction

  // Reference: owner (0 none, 1 cpu, 2 dma), cycle index of its last cycle, last winner.
  int          m_own  = 0;
  int          m_end  = 0;
  int          m_last = 2;
  int          cyc    = 0;
  logic [15:0] ref_mem [int];
  int          ack_seen = 0;
  int          ack_at   = 0;
  logic [15:0] last_cpu_rd = 16'h0000;

  function automatic logic [15:0] rd(input logic [15:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return init_val(a);
  endfunction

  task automatic present();
    cpu_vda = 1'b0;
    cpu_vpa = 1'b0;
    cpu_rnw = 1'b1;
    if (cpu_q.size() > 0) begin
      cpu_addr = cpu_q[0].addr;
      cpu_dout = cpu_q[0].data;
      case (cpu_q[0].kind)
        1: cpu_vpa = 1'b1;
        2: cpu_vda = 1'b1;
        3: begin cpu_vda = 1'b1; cpu_rnw = 1'b0; end
        default: ;
      endcase
    end
    dma_req = 1'b0;
    if (dma_q.size() > 0 && dma_q[0].kind != 0) begin
      dma_req   = 1'b1;
      dma_we    = (dma_q[0].kind == 2);
      dma_addr  = dma_q[0].addr;
      dma_wdata = dma_q[0].data;
    end
  endtask

  task automatic step();
    logic creq, cwr, e_wr, fin, c0, e_clken, e_ack, e_we, e_re, cc, dd;
    int   win;
    present();
    creq = cpu_vda | cpu_vpa;
    cwr  = cpu_vda & ~cpu_rnw;
    fin  = (m_own != 0) && (cyc == m_end);
    c0   = (m_own != 0) && (cyc == m_end - WS);
    e_wr = (m_own == 1) ? cwr : dma_we;
    if (reset) begin
      e_clken = 1'b1; e_ack = 1'b0; e_we = 1'b0; e_re = 1'b0;
    end else begin
      e_clken = (m_own == 1) ? fin : ~creq;
      e_ack   = (m_own == 2) && fin;
      e_we    = c0 && e_wr;
      e_re    = c0 && !e_wr;
    end
    @(negedge clk);
    chk("cpu_clken", 16'(cpu_clken), 16'(e_clken));
    chk("dma_ack",   16'(dma_ack),   16'(e_ack));
    chk("mem_we",    16'(mem_we),    16'(e_we));
    chk("mem_re",    16'(mem_re),    16'(e_re));
    if (dma_ack === 1'b1) begin ack_seen++; ack_at = cyc; end
    if (reset) begin
      chk("rst_mem_addr",  mem_addr,  16'h0000);
      chk("rst_mem_wdata", mem_wdata, 16'h0000);
    end else if (m_own != 0) begin
      chk("mem_addr", mem_addr, (m_own == 1) ? cpu_addr : dma_addr);
      if (e_we) chk("mem_wdata", mem_wdata, (m_own == 1) ? cpu_dout : dma_wdata);
      if (fin && m_own == 1 && !cwr) begin
        chk("cpu_din", cpu_din, rd(cpu_addr));
        last_cpu_rd = cpu_din;
      end
      if (e_ack && !dma_we) chk("dma_rdata", dma_rdata, rd(dma_addr));
    end
    if (reset) begin
      m_own  = 0;
      m_last = 2;
    end else begin
      if (e_we) ref_mem[int'((m_own == 1) ? cpu_addr : dma_addr)] = (m_own == 1) ? cpu_dout : dma_wdata;
      if (e_clken && cpu_q.size() > 0) void'(cpu_q.pop_front());
      if (dma_q.size() > 0 && (dma_q[0].kind == 0 || e_ack)) void'(dma_q.pop_front());
      if (m_own == 0 || fin) begin
        cc  = creq && (m_own != 1);
        dd  = dma_req && (m_own != 2);
        win = 0;
        if (cc && dd) win = (m_last == 1) ? 2 : 1;
        else if (cc)  win = 1;
        else if (dd)  win = 2;
        m_own = win;
        if (win != 0) begin
          m_end  = cyc + 1 + WS;
          m_last = win;
        end
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int budget);
    int n = 0;
    while ((cpu_q.size() > 0 || dma_q.size() > 0 || m_own != 0) && n < budget) begin
      step();
      n++;
    end
    chk("run_budget_left_ops", 16'(cpu_q.size() + dma_q.size()), 16'd0);
  endtask

  bit e3_clk [0:4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  bit e3_re  [0:4] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    int a0, base;
    reset = 1'b1;
    cpu_addr = '0; cpu_dout = '0; cpu_rnw = 1'b1; cpu_vda = 1'b0; cpu_vpa = 1'b0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
    c3_addr = '0; c3_vpa = 1'b0;
    @(posedge clk);
    #1;

    // Reset with both masters already requesting; CPU must win once released.
    cpu_q.push_back(mk(2, 16'h0010, 16'h0000));
    dma_q.push_back(mk(2, 16'h0011, 16'h7777));
    step();
    step();
    reset = 1'b0;
    run(40);

    // CPU read of a DMA-initialised word, then CPU write/read-back.
    dma_q.push_back(mk(2, 16'h0100, 16'hBEEF));
    run(20);
    cpu_q.push_back(mk(2, 16'h0100, 16'h0000));
    run(20);
    chk("cpu_read_0100", last_cpu_rd, 16'hBEEF);
    cpu_q.push_back(mk(3, 16'h0200, 16'h1234));
    cpu_q.push_back(mk(2, 16'h0200, 16'h0000));
    run(20);
    chk("cpu_read_0200", last_cpu_rd, 16'h1234);

    // Simultaneous first requests after reset: CPU then DMA, ack in 4th cycle.
    reset = 1'b1;
    step();
    reset = 1'b0;
    cpu_q.push_back(mk(1, 16'h0040, 16'h0000));
    dma_q.push_back(mk(1, 16'h0300, 16'h0000));
    a0   = ack_seen;
    base = cyc;
    run(20);
    chk("contend_ack_count", 16'(ack_seen - a0), 16'd1);
    chk("contend_ack_cycle", 16'(ack_at - base), 16'd4);

    // DMA streaming writes against a continuously fetching CPU.
    a0 = ack_seen;
    for (int i = 0; i < 4; i++) dma_q.push_back(mk(2, 16'hA000 + 16'(i), 16'h5000 + 16'(i)));
    for (int i = 0; i < 8; i++) cpu_q.push_back(mk(1, 16'h0400 + 16'(i), 16'h0000));
    run(60);
    chk("stream_ack_count", 16'(ack_seen - a0), 16'd4);
    for (int i = 0; i < 4; i++) cpu_q.push_back(mk(2, 16'hA000 + 16'(i), 16'h0000));
    run(30);
    chk("stream_last_word", last_cpu_rd, 16'h5003);

    // Reset during cycle 0 of a DMA access: the access is abandoned silently.
    dma_q.push_back(mk(1, 16'h0500, 16'h0000));
    step();
    dma_q.delete();
    reset = 1'b1;
    a0 = ack_seen;
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("abort_ack_count", 16'(ack_seen - a0), 16'd0);

    // DMA drops its request after grant: the access still completes with an ack.
    dma_q.push_back(mk(1, 16'h0600, 16'h0000));
    step();
    dma_q.delete();
    a0 = ack_seen;
    step();
    step();
    chk("drop_ack_count", 16'(ack_seen - a0), 16'd1);
    run(10);

    // Three wait states on the second instance.
    c3_addr = 16'h0040;
    c3_vpa  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("ws3_cpu_clken", 16'(c3_clken), 16'(e3_clk[i]));
      chk("ws3_mem_re",    16'(m3_re),    16'(e3_re[i]));
      chk("ws3_mem_we",    16'(m3_we),    16'd0);
      chk("ws3_dma_ack",   16'(d3_ack),   16'd0);
      if (i == 1) chk("ws3_mem_addr", m3_addr, 16'h0040);
      if (i == 4) chk("ws3_cpu_din", c3_din, init_val(16'h0040));
      @(posedge clk);
      #1;
    end
    c3_vpa = 1'b0;

    // Randomised mixed traffic over a small address window.
    for (int n = 0; n < 1500; n++) begin
      if (cpu_q.size() < 2)
        cpu_q.push_back(mk(int'($urandom_range(0, 3)), 16'($urandom_range(0, 31)), 16'($urandom)));
      if (dma_q.size() < 2 && $urandom_range(0, 2) != 0)
        dma_q.push_back(mk(int'($urandom_range(0, 2)), 16'($urandom_range(0, 31)), 16'($urandom)));
      step();
    end
    run(100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired before the directed sequence completed");
    $fatal(1);
  end

endmodule
`default_nettype wire
